// File: rtl/uart_pkg.sv
// Shared UART definitions: bit timing defaults, frame width and receiver state encoding.
package uart_pkg;

    localparam int CLKS_PER_BIT = 435;
    localparam int DATA_BITS    = 8;
    localparam int SYNC_STAGES  = 2;

    typedef enum logic [2:0] {
        ST_WAIT_HIGH = 3'd0,
        ST_IDLE      = 3'd1,
        ST_START     = 3'd2,
        ST_DATA      = 3'd3,
        ST_STOP      = 3'd4
    } rx_state_t;

    function automatic logic is_busy(input rx_state_t s);
        return s inside {ST_START, ST_DATA, ST_STOP};
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser bringing the asynchronous serial line into the rx_clk domain.
module uart_rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic rx_clk,
    input  logic nRST,
    input  logic async_in,
    output logic sync_out
);

    logic meta;

    // NOTE: non-blocking assignments so both flops sample their inputs from before the edge.
    always_ff @(posedge rx_clk) begin
        if (!nRST) begin
            meta     <= RESET_VAL;
            sync_out <= RESET_VAL;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling of a synchronised line, one-cycle valid / framing-error strobes.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       rx_clk,
    input  logic       nRST,
    input  logic       rx_input,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_FLUSHED   = CNT_W'(SYNC_STAGES);
    localparam logic [IDX_W-1:0] IDX_LAST      = IDX_W'(DATA_BITS - 1);

    logic rx_sync;

    uart_rx_sync #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .rx_clk   (rx_clk),
        .nRST     (nRST),
        .async_in (rx_input),
        .sync_out (rx_sync)
    );

    rx_state_t      state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [IDX_W-1:0] bit_idx, bit_idx_nxt;
    logic [7:0]     shift, shift_nxt;
    logic [7:0]     rx_data_nxt;
    logic           rx_valid_nxt;
    logic           rx_frame_err_nxt;

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_nxt        = state;
        cnt_nxt          = cnt;
        bit_idx_nxt      = bit_idx;
        shift_nxt        = shift;
        rx_data_nxt      = rx_data;
        rx_valid_nxt     = 1'b0;
        rx_frame_err_nxt = 1'b0;

        unique case (state)
            // The synchroniser's reset value is not a real observation of the line, so
            // rx_sync is only trusted once both stages have been refilled from rx_input.
            ST_WAIT_HIGH: begin
                if (cnt < CNT_FLUSHED) begin
                    cnt_nxt = cnt + CNT_W'(1);
                end else if (rx_sync) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            end

            ST_IDLE: begin
                cnt_nxt = '0;
                if (!rx_sync) begin
                    state_nxt = ST_START;
                end
            end

            ST_START: begin
                if (cnt == CNT_HALF_LAST) begin
                    cnt_nxt     = '0;
                    bit_idx_nxt = '0;
                    state_nxt   = rx_sync ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            ST_DATA: begin
                if (cnt == CNT_BIT_LAST) begin
                    cnt_nxt     = '0;
                    shift_nxt   = {rx_sync, shift[7:1]};
                    bit_idx_nxt = bit_idx + IDX_W'(1);
                    if (bit_idx == IDX_LAST) begin
                        state_nxt = ST_STOP;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            // Leaving at mid-stop lets a start bit directly after the stop bit be caught.
            ST_STOP: begin
                if (cnt == CNT_BIT_LAST) begin
                    cnt_nxt = '0;
                    if (rx_sync) begin
                        rx_data_nxt  = shift;
                        rx_valid_nxt = 1'b1;
                        state_nxt    = ST_IDLE;
                    end else begin
                        rx_frame_err_nxt = 1'b1;
                        state_nxt        = ST_WAIT_HIGH;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            default: begin
                state_nxt = ST_WAIT_HIGH;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge rx_clk) begin
        if (!nRST) begin
            state        <= ST_WAIT_HIGH;
            cnt          <= '0;
            bit_idx      <= '0;
            rx_data      <= 8'h00;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            bit_idx      <= bit_idx_nxt;
            rx_data      <= rx_data_nxt;
            rx_valid     <= rx_valid_nxt;
            rx_frame_err <= rx_frame_err_nxt;
        end
    end

    // NOTE: the shift register is pure datapath, fully overwritten before it is read, so it has no reset.
    always_ff @(posedge rx_clk) begin
        shift <= shift_nxt;
    end

    assign rx_busy = is_busy(state);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame-level timing model compared every cycle, plus directed literal checks.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int CPB  = 435;
    localparam int HALF = CPB / 2;
    localparam int LAT  = 2 + HALF + 9 * CPB;  // 4134

    logic       rx_clk = 1'b0;
    logic       nRST;
    logic       rx_input;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_busy;

    uart_rx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .rx_clk       (rx_clk),
        .nRST         (nRST),
        .rx_input     (rx_input),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .rx_busy      (rx_busy)
    );

    always #5 rx_clk = ~rx_clk;

    // Each frame on the line is described by when its start bit is first captured (e0),
    // the last cycle rx_busy should be high, and what it should produce at e0+LAT.
    typedef enum {K_GOOD, K_FERR, K_QUIET} kind_t;
    typedef struct {
        int         e0;
        int         last_busy;
        kind_t      kind;
        logic [7:0] data;
    } frame_t;

    frame_t     frames[$];
    int         valid_q[$];
    logic [7:0] valid_d[$];
    int         ferr_cnt = 0;
    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    bit         rst_edge = 1'b0;
    bit         armed = 1'b0;
    logic [7:0] exp_data = 8'h00;
    logic       exp_v, exp_f, exp_b;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    always @(posedge rx_clk) begin
        cyc      <= cyc + 1;
        rst_edge <= !nRST;
    end

    // Reference compare: cyc is the number of the rising edge just taken.
    always @(negedge rx_clk) begin
        if (rst_edge) begin
            armed    = 1'b1;
            exp_data = 8'h00;
        end
        if (armed) begin
            exp_v = 1'b0;
            exp_f = 1'b0;
            exp_b = 1'b0;
            foreach (frames[i]) begin
                if (cyc >= frames[i].e0 + 2 && cyc <= frames[i].last_busy) exp_b = 1'b1;
                if (cyc == frames[i].e0 + LAT) begin
                    if (frames[i].kind == K_GOOD) begin
                        exp_v    = 1'b1;
                        exp_data = frames[i].data;
                    end
                    if (frames[i].kind == K_FERR) exp_f = 1'b1;
                end
            end
            check($sformatf("outputs@%0d", cyc),
                  {21'd0, rx_data, rx_valid, rx_frame_err, rx_busy},
                  {21'd0, exp_data, exp_v, exp_f, exp_b});
            if (rx_valid) begin
                valid_q.push_back(cyc);
                valid_d.push_back(rx_data);
            end
            if (rx_frame_err) ferr_cnt++;
        end
    end

    task automatic idle(input int n);
        rx_input = 1'b1;
        repeat (n) @(negedge rx_clk);
    endtask

    task automatic drive_bits(input logic [7:0] d, input logic stop);
        rx_input = 1'b0;
        repeat (CPB) @(negedge rx_clk);
        for (int i = 0; i < 8; i++) begin
            rx_input = d[i];
            repeat (CPB) @(negedge rx_clk);
        end
        rx_input = stop;
        repeat (CPB) @(negedge rx_clk);
    endtask

    task automatic send(input logic [7:0] d, input logic stop);
        frame_t f;
        f.e0        = cyc + 1;
        f.last_busy = f.e0 + LAT - 1;
        f.kind      = stop ? K_GOOD : K_FERR;
        f.data      = d;
        frames.push_back(f);
        drive_bits(d, stop);
    endtask

    task automatic glitch(input int len);
        frame_t f;
        f.e0        = cyc + 1;
        f.last_busy = f.e0 + HALF + 1;
        f.kind      = K_QUIET;
        f.data      = 8'h00;
        frames.push_back(f);
        rx_input = 1'b0;
        repeat (len) @(negedge rx_clk);
        rx_input = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int         v0, f0, e0, c0, n_good;
        logic [7:0] d;
        logic       stop;
        frame_t     f;

        // Reset with the line idle.
        nRST     = 1'b0;
        rx_input = 1'b1;
        repeat (5) @(negedge rx_clk);
        check("reset_data", rx_data, 8'h00);
        check("reset_valid", rx_valid, 0);
        check("reset_ferr", rx_frame_err, 0);
        check("reset_busy", rx_busy, 0);
        check("reset_state", dut.state, ST_WAIT_HIGH);
        nRST = 1'b1;
        @(negedge rx_clk);
        check("wait_high_after_release", dut.state, ST_WAIT_HIGH);
        repeat (5) @(negedge rx_clk);
        check("idle_after_release", dut.state, ST_IDLE);

        // Single good frame 0xA5.
        idle(100);
        v0 = valid_q.size();
        e0 = cyc + 1;
        send(8'hA5, 1'b1);
        idle(50);
        check("a5_pulses", valid_q.size() - v0, 1);
        if (valid_q.size() > v0) check("a5_latency", valid_q[v0] - e0, 4134);
        check("a5_data", rx_data, 8'hA5);
        check("a5_no_ferr", ferr_cnt, 0);

        // Short low glitch on an idle line.
        v0 = valid_q.size();
        glitch(100);
        check("glitch_busy_high", rx_busy, 1);
        idle(300);
        check("glitch_busy_low", rx_busy, 0);
        check("glitch_no_valid", valid_q.size() - v0, 0);
        check("glitch_no_ferr", ferr_cnt, 0);

        // Bad stop bit, line then held low 1000 clocks after the data bits.
        v0 = valid_q.size();
        send(8'h3C, 1'b0);
        rx_input = 1'b0;
        repeat (1000 - CPB) @(negedge rx_clk);
        check("ferr_pulses", ferr_cnt, 1);
        check("ferr_data_held", rx_data, 8'hA5);
        check("ferr_no_valid", valid_q.size() - v0, 0);
        idle(100);
        send(8'h01, 1'b1);
        idle(20);
        check("after_ferr_data", rx_data, 8'h01);

        // Back-to-back 0x00 / 0xFF with no idle gap.
        v0 = valid_q.size();
        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        idle(20);
        check("b2b_pulses", valid_q.size() - v0, 2);
        if (valid_q.size() >= v0 + 2) begin
            check("b2b_spacing", valid_q[v0 + 1] - valid_q[v0], 4350);
            check("b2b_first", valid_d[v0], 8'h00);
            check("b2b_second", valid_d[v0 + 1], 8'hFF);
        end

        // Reset during data bit 4 (line low), released while still low.
        v0 = valid_q.size();
        f0 = ferr_cnt;
        idle(100);
        c0          = cyc;
        f.e0        = c0 + 1;
        f.last_busy = c0 + 5 * CPB + 200;
        f.kind      = K_QUIET;
        f.data      = 8'h00;
        frames.push_back(f);
        fork
            drive_bits(8'hE0, 1'b1);
            begin
                repeat (5 * CPB + 200) @(negedge rx_clk);
                nRST = 1'b0;
                repeat (5) @(negedge rx_clk);
                nRST = 1'b1;
            end
        join
        idle(200);
        check("abort_no_valid", valid_q.size() - v0, 0);
        check("abort_no_ferr", ferr_cnt - f0, 0);
        check("abort_data_cleared", rx_data, 8'h00);
        send(8'h5A, 1'b1);
        idle(20);
        check("after_abort_data", rx_data, 8'h5A);

        // Randomised traffic: random bytes, gaps, glitches and occasional bad stop bits.
        for (int k = 0; k < 6; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                glitch($urandom_range(1, 150));
                idle(300);
            end
            d    = 8'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            send(d, stop);
            if (!stop)
                idle($urandom_range(20, 400));
            else if ($urandom_range(0, 2) == 0)
                idle(0);
            else
                idle($urandom_range(1, 600));
        end
        idle(4400);

        n_good = 0;
        foreach (frames[i]) if (frames[i].kind == K_GOOD) n_good++;
        check("total_valid_pulses", valid_q.size(), n_good);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
